// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory request/response bus
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           Instruction;

  // fetch unit drives the word address, memory answers in the same cycle
  modport master (output Address, input Instruction);
  modport slave  (input Address, output Instruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and IF/ID register; optional FETCH_PERF_CNT_EN counters
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 128,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_fetch_unit_if.master imem,
  input  logic                  Stall,
  input  logic                  BranchTaken,
  input  logic [15:0]           BranchOffset,
  output logic [31:0]           IfIdInstruction,
  output logic [ADDR_WIDTH-1:0] IfIdPC,
  output logic                  IfIdValid,
  output logic                  Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           FetchCount,
  output logic [31:0]           BubbleCount
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [ADDR_WIDTH-1:0] ifid_pc_n;
  logic [31:0]           ifid_instr_n;
  logic                  ifid_valid_n;

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] br_target;
  logic                  take_br;
  logic                  fetch_inc;
  logic                  bubble_inc;

  // a branch only counts when it belongs to a real instruction in IF/ID
  assign take_br   = BranchTaken && IfIdValid;
  assign seq_pc    = pc + ADDR_WIDTH'(1);
  assign br_target = IfIdPC + ADDR_WIDTH'(1)
                   + {{(ADDR_WIDTH-16){BranchOffset[15]}}, BranchOffset};

  // state register together with PC and IF/ID pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BOOT;
      pc              <= RST_PC;
      IfIdInstruction <= '0;
      IfIdPC          <= '0;
      IfIdValid       <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      IfIdInstruction <= ifid_instr_n;
      IfIdPC          <= ifid_pc_n;
      IfIdValid       <= ifid_valid_n;
    end
  end

  // next state and next datapath values; branch beats stall, halt on any out-of-range PC load
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ifid_instr_n = IfIdInstruction;
    ifid_pc_n    = IfIdPC;
    ifid_valid_n = IfIdValid;
    fetch_inc    = 1'b0;
    bubble_inc   = 1'b0;
    case (state)
      BOOT: begin
        state_n = (RST_PC >= DEPTH) ? HALT : RUN;
      end
      RUN: begin
        if (take_br) begin
          pc_n         = br_target;
          ifid_valid_n = 1'b0;
          bubble_inc   = 1'b1;
          state_n      = (br_target >= DEPTH) ? HALT : RUN;
        end else if (!Stall) begin
          ifid_instr_n = imem.Instruction;
          ifid_pc_n    = pc;
          ifid_valid_n = 1'b1;
          pc_n         = seq_pc;
          fetch_inc    = 1'b1;
          state_n      = (seq_pc >= DEPTH) ? HALT : RUN;
        end
      end
      HALT: begin
        // the last captured word may still branch us back into range
        ifid_valid_n = 1'b0;
        bubble_inc   = IfIdValid;
        if (take_br && (br_target < DEPTH)) begin
          pc_n    = br_target;
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  // outputs decoded from state and PC
  always_comb begin
    Halted       = (state == HALT);
    imem.Address = pc;
  end

`ifdef FETCH_PERF_CNT_EN
  // saturating fetch and bubble counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount  <= '0;
      BubbleCount <= '0;
    end else begin
      if (fetch_inc && (FetchCount != 32'hFFFF_FFFF))
        FetchCount <= FetchCount + 32'd1;
      if (bubble_inc && (BubbleCount != 32'hFFFF_FFFF))
        BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchOffset;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPC;
  logic        IfIdValid;
  logic        Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:127];

  instruction_fetch_unit_if #(.ADDR_WIDTH(32)) imem_if ();

  instruction_fetch_unit #(.ADDR_WIDTH(32), .MEM_DEPTH(128), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imem_if.master),
    .Stall           (Stall),
    .BranchTaken     (BranchTaken),
    .BranchOffset    (BranchOffset),
    .IfIdInstruction (IfIdInstruction),
    .IfIdPC          (IfIdPC),
    .IfIdValid       (IfIdValid),
    .Halted          (Halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount      (FetchCount),
    .BubbleCount     (BubbleCount)
`endif
  );

  assign imem_if.Instruction = (imem_if.Address < 32'd128) ? mem[imem_if.Address[6:0]] : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    Stall = 1'b0;
    BranchTaken = 1'b0;
    BranchOffset = 16'h0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'hACC5_0000;
    mem[1]  = 32'h8C6A_0003;
    mem[7]  = 32'h1294_0007;
    mem[15] = 32'h000A_5022;

    do_reset();
    check("rst_addr",  imem_if.Address, 32'd0);
    check("rst_valid", IfIdValid, 1'b0);
    check("rst_pc",    IfIdPC, 32'd0);
    check("rst_instr", IfIdInstruction, 32'd0);
    check("rst_halt",  Halted, 1'b0);

    tick(1);
    check("boot_valid", IfIdValid, 1'b0);
    check("boot_addr",  imem_if.Address, 32'd0);
    tick(1);
    check("f0_instr", IfIdInstruction, 32'hACC5_0000);
    check("f0_pc",    IfIdPC, 32'd0);
    check("f0_valid", IfIdValid, 1'b1);
    check("f0_addr",  imem_if.Address, 32'd1);
    tick(1);
    check("f1_instr", IfIdInstruction, 32'h8C6A_0003);
    check("f1_pc",    IfIdPC, 32'd1);

    tick(2);
    check("pre_stall_pc", IfIdPC, 32'd3);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_pc",    IfIdPC, 32'd3);
      check("stall_addr",  imem_if.Address, 32'd4);
      check("stall_instr", IfIdInstruction, 32'h1000_0003);
    end
    Stall = 1'b0;
    tick(1);
    check("unstall_pc", IfIdPC, 32'd4);

    tick(3);
    check("beq_pc",    IfIdPC, 32'd7);
    check("beq_instr", IfIdInstruction, 32'h1294_0007);
    Stall = 1'b1;
    BranchTaken = 1'b1;
    BranchOffset = 16'd7;
    tick(1);
    check("br_bubble", IfIdValid, 1'b0);
    check("br_addr",   imem_if.Address, 32'd15);
    check("br_pc_hold", IfIdPC, 32'd7);
    Stall = 1'b0;
    tick(1);
    check("tgt_pc",    IfIdPC, 32'd15);
    check("tgt_instr", IfIdInstruction, 32'h000A_5022);
    check("tgt_valid", IfIdValid, 1'b1);
    check("tgt_addr",  imem_if.Address, 32'd16);
    BranchTaken = 1'b0;

    tick(112);
    check("end_pc",    IfIdPC, 32'd127);
    check("end_valid", IfIdValid, 1'b1);
    check("end_halt",  Halted, 1'b1);
    check("end_addr",  imem_if.Address, 32'd128);
    tick(1);
    check("halt_valid", IfIdValid, 1'b0);
    check("halt_addr",  imem_if.Address, 32'd128);
    BranchTaken = 1'b1;
    BranchOffset = 16'hFF80;
    tick(1);
    check("halt_br_ign", Halted, 1'b1);
    check("halt_br_addr", imem_if.Address, 32'd128);

    do_reset();
    tick(129);
    check("end2_pc",   IfIdPC, 32'd127);
    check("end2_halt", Halted, 1'b1);
    BranchTaken = 1'b1;
    BranchOffset = 16'hFF80;
    tick(1);
    check("resume_halt",  Halted, 1'b0);
    check("resume_addr",  imem_if.Address, 32'd0);
    check("resume_valid", IfIdValid, 1'b0);
    BranchTaken = 1'b0;
    tick(1);
    check("resume_instr", IfIdInstruction, 32'hACC5_0000);
    check("resume_valid2", IfIdValid, 1'b1);

    tick(5);
    check("neg_pc", IfIdPC, 32'd5);
    BranchTaken = 1'b1;
    BranchOffset = 16'hFFEC;
    tick(1);
    check("neg_halt",  Halted, 1'b1);
    check("neg_addr",  imem_if.Address, 32'hFFFF_FFF2);
    check("neg_valid", IfIdValid, 1'b0);
    BranchTaken = 1'b0;
    tick(1);
    check("neg_hold", imem_if.Address, 32'hFFFF_FFF2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr",  imem_if.Address, 32'd0);
    check("arst_halt",  Halted, 1'b0);
    check("arst_valid", IfIdValid, 1'b0);
    check("arst_pc",    IfIdPC, 32'd0);
    check("arst_instr", IfIdInstruction, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    tick(11);
    check("perf_pc", IfIdPC, 32'd9);
    BranchTaken = 1'b1;
    BranchOffset = 16'd2;
    tick(1);
    BranchTaken = 1'b0;
    check("perf_fetch",  FetchCount, 32'd10);
    check("perf_bubble", BubbleCount, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Requester side of the instruction memory interface: owns the program counter, drives the word address into the 128-entry instruction memory and captures the returned word into the IF/ID pipeline register. Handles decode-stage stalls, taken-branch redirects (`beq` word-offset semantics) and halts cleanly when the PC leaves the populated memory range. Sits between the instruction memory and the decode/register-file stage of the 32-bit MIPS pipeline.

## Interface
- `ADDR_WIDTH`, 32: width of PC and memory address (word index).
- `MEM_DEPTH`, 128: number of valid instruction words; legal PCs are 0..MEM_DEPTH-1.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Address`  out  ADDR_WIDTH  word index driven to instruction memory; always equals PC.
- `Instruction`  in  32  instruction word returned combinationally for `Address`, same cycle.
- `Stall`  in  1  decode hazard; hold PC and IF/ID contents.
- `BranchTaken`  in  1  decode resolved a taken branch for the instruction currently in IF/ID.
- `BranchOffset`  in  16  signed word offset from the branch immediate field.
- `IfIdInstruction`  out  32  captured instruction.
- `IfIdPC`  out  ADDR_WIDTH  PC of the captured instruction.
- `IfIdValid`  out  1  IF/ID contents are a real instruction (0 = bubble).
- `Halted`  out  1  fetch stopped; PC out of range.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: lasts exactly one cycle after `rst_n` deasserts; no capture; next state RUN (or HALT if RESET_PC >= MEM_DEPTH).
- RUN, per rising edge, priority order:
  - `BranchTaken`: PC <= IfIdPC + 1 + sign_extend(BranchOffset) (mod 2^ADDR_WIDTH); IfIdValid <= 0 (flush the sequential fetch); IfIdInstruction/IfIdPC hold. Overrides `Stall`.
  - `Stall`: PC, IfIdInstruction, IfIdPC, IfIdValid all hold.
  - else: IfIdInstruction <= Instruction; IfIdPC <= PC; IfIdValid <= 1; PC <= PC + 1.
- Transition to HALT whenever the PC value being loaded is >= MEM_DEPTH (sequential wrap-off or branch target, including negative targets wrapping to large values). Memory is never addressed out of range for capture.
- HALT: `Halted`=1; IfIdValid <= 0 on the first HALT edge and stays 0; PC holds. `BranchTaken` in HALT with an in-range target returns to RUN with the new PC; `Stall` ignored. Leaving HALT otherwise requires reset.
- `BranchTaken` is only honoured when IfIdValid=1; with IfIdValid=0 it is ignored.

## Timing
- Reset values: PC=RESET_PC, `Address`=RESET_PC, IfIdInstruction=0, IfIdPC=0, IfIdValid=0, Halted=0, state BOOT.
- `Address` is combinational from the PC register; memory word captured on the same edge (fetch latency 1 cycle, address to IF/ID).
- First valid instruction: IMEM[RESET_PC] appears in IF/ID on the 2nd rising edge after reset release.
- Branch penalty: exactly one bubble cycle; target instruction valid in IF/ID two edges after the `BranchTaken` edge.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous), regardless of Stall/Branch.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds outputs `FetchCount` (32) and `BubbleCount` (32), reset to 0; FetchCount +1 on each edge loading IfIdValid=1, BubbleCount +1 on each edge loading IfIdValid=0 in RUN (flush) or first HALT edge; both saturate at 0xFFFFFFFF and hold during Stall.
- When undefined: ports and counters absent; fetch behaviour identical.

## Test plan
- Reset release, memory loaded with IMEM[0]=0xACC50000, IMEM[1]=0x8C6A0003 -> BOOT cycle IfIdValid=0; next edge IfIdInstruction=0xACC50000, IfIdPC=0; following edge 0x8C6A0003, IfIdPC=1.
- Run to IfIdPC=7 holding `beq $20,$20,7`, assert BranchTaken with BranchOffset=7 -> one bubble (IfIdValid=0), then IfIdPC=15, IfIdInstruction=IMEM[15]=0x000A5022.
- Assert Stall for 3 cycles with IfIdPC=3 -> IF/ID and Address unchanged for 3 edges; release -> IfIdPC=4; simultaneous Stall and BranchTaken -> branch wins.
- Sequential fetch to PC=127 -> IfIdPC=127 valid, then Halted=1, IfIdValid=0 held; BranchTaken with offset -128 from IfIdPC=127 -> target 0, RUN resumes.
- Branch offset -20 from IfIdPC=5 -> target wraps out of range, Halted=1 next edge; assert rst_n=0 mid-HALT -> all outputs zero/RESET_PC asynchronously.
- With FETCH_PERF_CNT_EN, 10 sequential fetches plus one taken branch -> FetchCount=10, BubbleCount=1.
